// File: rtl/ballot_capture.sv
`default_nettype none
// ============================================================================
// Module   : ballot_capture
// Brief    : Voter front end. Qualifies a stable one-hot selection on CAST and
//            emits one single-cycle one-hot vote per accepted ballot.
// Revision : 1.0 - initial release
// ============================================================================
module ballot_capture #(
    parameter int N_CAND        = 8,
    parameter int MAX_VOTES     = 9,
    parameter int STABLE_CYCLES = 3,
    localparam int CNT_W        = $clog2(MAX_VOTES + 1),
    localparam int STAB_W       = $clog2(STABLE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_CAND-1:0] btn,
    input  logic              cast,
    output logic [N_CAND-1:0] data,
    output logic              vote_valid,
    output logic              reject,
    output logic [CNT_W-1:0]  vote_cnt,
    output logic              active,
    output logic              done
);

    localparam logic [STAB_W-1:0] c_stab_max  = STAB_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  c_max_votes = CNT_W'(MAX_VOTES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_CAND-1:0]   r_btn_q;
    logic [STAB_W-1:0]   r_stab_cnt;
    logic [N_CAND-1:0]   w_data_nxt;
    logic                w_valid_nxt;
    logic                w_reject_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_onehot;
    logic                w_qualified;
    logic                w_enter_select;

    assign w_onehot    = (r_btn_q != '0) && ((r_btn_q & (r_btn_q - N_CAND'(1))) == '0);
    assign w_qualified = (btn == r_btn_q) && (r_stab_cnt == c_stab_max) && w_onehot;
    assign w_enter_select = (w_state_nxt == SELECT) && (r_state != SELECT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = '0;
        w_valid_nxt  = 1'b0;
        w_reject_nxt = 1'b0;
        w_cnt_nxt    = vote_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SELECT;
                    w_cnt_nxt   = '0;
                end
            end
            SELECT: begin
                if (cast) begin
                    if (w_qualified) begin
                        w_data_nxt  = r_btn_q;
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = vote_cnt + CNT_W'(1);
                        w_state_nxt = (w_cnt_nxt == c_max_votes) ? DONE : RELEASE;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            RELEASE: begin
                // Voter must let go of everything before another ballot is possible.
                if ((btn == '0) && !cast) begin
                    w_state_nxt = SELECT;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = SELECT;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_q    <= '0;
            r_stab_cnt <= '0;
        end else begin
            r_btn_q <= btn;
            if (w_enter_select || (btn != r_btn_q)) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != c_stab_max) begin
                r_stab_cnt <= r_stab_cnt + STAB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            vote_valid <= 1'b0;
            reject     <= 1'b0;
            vote_cnt   <= '0;
            active     <= 1'b0;
            done       <= 1'b0;
        end else begin
            data       <= w_data_nxt;
            vote_valid <= w_valid_nxt;
            reject     <= w_reject_nxt;
            vote_cnt   <= w_cnt_nxt;
            active     <= (w_state_nxt == SELECT) || (w_state_nxt == RELEASE);
            done       <= (w_state_nxt == DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ballot_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ballot_capture
// Brief    : Directed self-checking bench for ballot_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ballot_capture;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] btn;
    logic       cast;
    logic [7:0] data;
    logic       vote_valid;
    logic       reject;
    logic [3:0] vote_cnt;
    logic       active;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    ballot_capture #(
        .N_CAND        (8),
        .MAX_VOTES     (9),
        .STABLE_CYCLES (3)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .btn        (btn),
        .cast       (cast),
        .data       (data),
        .vote_valid (vote_valid),
        .reject     (reject),
        .vote_cnt   (vote_cnt),
        .active     (active),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full ballot: hold selection long enough to qualify, cast, then release.
    task automatic vote(input logic [7:0] cand, input logic [3:0] exp_cnt);
        btn = cand;
        step(5);
        cast = 1'b1;
        step(1);
        chk("vote_data", data, cand);
        chk("vote_valid", vote_valid, 1'b1);
        chk("vote_cnt", vote_cnt, exp_cnt);
        cast = 1'b0;
        btn  = 8'h00;
        step(1);
        chk("vote_pulse_end", data, 8'h00);
    endtask

    initial begin
        int n_votes;
        int n_rej;
        rst   = 1'b1;
        start = 1'b0;
        btn   = 8'h00;
        cast  = 1'b0;
        step(2);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", vote_valid, 1'b0);
        chk("rst_reject", reject, 1'b0);
        chk("rst_cnt", vote_cnt, 4'd0);
        chk("rst_active", active, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        step(1);

        // 1. basic vote
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t1_active", active, 1'b1);
        btn = 8'h04;
        step(5);
        cast = 1'b1;
        step(1);
        cast = 1'b0;
        chk("t1_data", data, 8'h04);
        chk("t1_valid", vote_valid, 1'b1);
        chk("t1_cnt", vote_cnt, 4'd1);
        chk("t1_reject", reject, 1'b0);
        step(1);
        chk("t1_data_clr", data, 8'h00);
        chk("t1_valid_clr", vote_valid, 1'b0);
        chk("t1_release_active", active, 1'b1);
        btn = 8'h00;
        step(1);

        // 2. multi-hot, then bouncing selection
        btn = 8'h05;
        step(5);
        cast = 1'b1;
        step(1);
        cast = 1'b0;
        chk("t2_mh_reject", reject, 1'b1);
        chk("t2_mh_data", data, 8'h00);
        chk("t2_mh_cnt", vote_cnt, 4'd1);
        step(1);
        chk("t2_mh_reject_clr", reject, 1'b0);
        for (int i = 0; i < 6; i++) begin
            btn = i[0] ? 8'h00 : 8'h02;
            step(1);
        end
        btn  = 8'h02;
        cast = 1'b1;
        step(1);
        cast = 1'b0;
        chk("t2_bounce_reject", reject, 1'b1);
        chk("t2_bounce_valid", vote_valid, 1'b0);
        chk("t2_bounce_cnt", vote_cnt, 4'd1);
        btn = 8'h00;
        step(1);

        // 3. release lockout
        btn = 8'h80;
        step(5);
        cast = 1'b1;
        n_votes = 0;
        n_rej   = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (vote_valid) n_votes++;
            if (reject) n_rej++;
            if (i == 0) chk("t3_data", data, 8'h80);
        end
        chk("t3_votes", n_votes, 1);
        chk("t3_rejects", n_rej, 0);
        chk("t3_cnt", vote_cnt, 4'd2);
        cast = 1'b0;
        step(3);
        chk("t3_btn_held_valid", vote_valid, 1'b0);
        cast = 1'b1;
        btn  = 8'h80;
        step(1);
        chk("t3_recast_valid", vote_valid, 1'b0);
        chk("t3_recast_reject", reject, 1'b0);
        cast = 1'b0;
        btn  = 8'h00;
        step(1);

        // 4. session close after nine ballots
        vote(8'h01, 4'd3);
        vote(8'h02, 4'd4);
        vote(8'h08, 4'd5);
        vote(8'h10, 4'd6);
        vote(8'h20, 4'd7);
        vote(8'h40, 4'd8);
        vote(8'h04, 4'd9);
        chk("t4_cnt", vote_cnt, 4'd9);
        chk("t4_done", done, 1'b1);
        chk("t4_active", active, 1'b0);
        btn = 8'h01;
        step(5);
        cast = 1'b1;
        step(1);
        cast = 1'b0;
        chk("t4_done_valid", vote_valid, 1'b0);
        chk("t4_done_data", data, 8'h00);
        chk("t4_done_reject", reject, 1'b0);
        chk("t4_done_cnt", vote_cnt, 4'd9);
        btn   = 8'h00;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t4_restart_cnt", vote_cnt, 4'd0);
        chk("t4_restart_done", done, 1'b0);
        chk("t4_restart_active", active, 1'b1);

        // 5. async reset during a vote pulse
        btn = 8'h10;
        step(5);
        cast = 1'b1;
        step(1);
        chk("t5_pre_valid", vote_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_data", data, 8'h00);
        chk("t5_async_valid", vote_valid, 1'b0);
        chk("t5_async_cnt", vote_cnt, 4'd0);
        chk("t5_async_active", active, 1'b0);
        rst = 1'b0;
        n_votes = 0;
        n_rej   = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (vote_valid) n_votes++;
            if (reject) n_rej++;
        end
        chk("t5_idle_votes", n_votes, 0);
        chk("t5_idle_rejects", n_rej, 0);
        chk("t5_idle_active", active, 1'b0);

        // 6. start and cast together in IDLE
        start = 1'b1;
        step(1);
        start = 1'b0;
        cast  = 1'b0;
        chk("t6_active", active, 1'b1);
        chk("t6_valid", vote_valid, 1'b0);
        chk("t6_reject", reject, 1'b0);
        step(1);
        chk("t6_after_valid", vote_valid, 1'b0);
        chk("t6_after_reject", reject, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
